// File: rtl/decode_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// decode_hazard_ctrl
//
// Decode-stage sequencer for a 5-stage pipeline. It owns the IF/ID and ID/EX
// pipeline registers, decodes the opcode in D to select the immediate format,
// captures the extended immediate into EX, and generates load-use stall and
// branch/jump flush controls. Saturating counters record stall and flush
// events.
//
// Ports:
//   clk        in   system clock, all state on rising edge
//   reset      in   synchronous active-high reset
//   InstrF     in   fetched instruction
//   PCSrcE     in   taken branch/jump resolved in EX
//   ImmExtD    in   extended immediate (combinational on InstrD/ImmSrcD)
//   InstrD     out  IF/ID register contents
//   ImmSrcD    out  immediate format: 00 I, 01 S, 10 B, 11 J
//   IllegalD   out  unsupported opcode in D
//   ImmExtE    out  ID/EX immediate
//   Rs1E/Rs2E/RdE out ID/EX register indices
//   RegWriteE  out  EX instruction writes rd
//   LoadE      out  EX instruction is a load
//   StallF/StallD/FlushD/FlushE out hazard controls
//   StallCnt/FlushCnt out saturating event counters
// -----------------------------------------------------------------------------
module decode_hazard_ctrl #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      InstrF,
  input  logic             PCSrcE,
  input  logic [31:0]      ImmExtD,
  output logic [31:0]      InstrD,
  output logic [1:0]       ImmSrcD,
  output logic             IllegalD,
  output logic [31:0]      ImmExtE,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic             RegWriteE,
  output logic             LoadE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0] imm_src_s;
  logic       reg_write_s;
  logic       load_s;
  logic       use_rs1_s;
  logic       use_rs2_s;
  logic       illegal_s;
  logic       lw_stall_s;

  // Opcode decoder for the instruction sitting in D.
  always_comb begin
    imm_src_s   = 2'b00;
    reg_write_s = 1'b0;
    load_s      = 1'b0;
    use_rs1_s   = 1'b0;
    use_rs2_s   = 1'b0;
    illegal_s   = 1'b0;
    case (InstrD[6:0])
      7'b0000011: begin  // load
        reg_write_s = 1'b1;
        load_s      = 1'b1;
        use_rs1_s   = 1'b1;
      end
      7'b0010011: begin  // ALU immediate
        reg_write_s = 1'b1;
        use_rs1_s   = 1'b1;
      end
      7'b1100111: begin  // jalr
        reg_write_s = 1'b1;
        use_rs1_s   = 1'b1;
      end
      7'b0110011: begin  // R-type
        reg_write_s = 1'b1;
        use_rs1_s   = 1'b1;
        use_rs2_s   = 1'b1;
      end
      7'b0100011: begin  // store
        imm_src_s = 2'b01;
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
      end
      7'b1100011: begin  // branch
        imm_src_s = 2'b10;
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
      end
      7'b1101111: begin  // jal
        imm_src_s   = 2'b11;
        reg_write_s = 1'b1;
      end
      default: begin     // lui/auipc and anything else are not supported
        illegal_s = 1'b1;
      end
    endcase
  end

  assign ImmSrcD  = imm_src_s;
  assign IllegalD = illegal_s;

  // A load writing x0 never creates a real dependency, so it cannot stall.
  assign lw_stall_s = LoadE & (RdE != 5'd0) &
                      ((use_rs1_s & (RdE == InstrD[19:15])) |
                       (use_rs2_s & (RdE == InstrD[24:20])));

  assign StallF = lw_stall_s;
  assign StallD = lw_stall_s;
  assign FlushD = PCSrcE;
  assign FlushE = lw_stall_s | PCSrcE;

  // IF/ID register: flush has priority over stall.
  always_ff @(posedge clk) begin
    if (reset || FlushD) begin
      InstrD <= NOP_INSTR;
    end else if (!StallD) begin
      InstrD <= InstrF;
    end else begin
      InstrD <= InstrD;
    end
  end

  // ID/EX register: a flush inserts an all-zero bubble, which also clears LoadE
  // so a load-use stall releases after exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      ImmExtE   <= 32'h0000_0000;
      Rs1E      <= 5'd0;
      Rs2E      <= 5'd0;
      RdE       <= 5'd0;
      RegWriteE <= 1'b0;
      LoadE     <= 1'b0;
    end else begin
      ImmExtE   <= ImmExtD;
      Rs1E      <= InstrD[19:15];
      Rs2E      <= InstrD[24:20];
      RdE       <= InstrD[11:7];
      RegWriteE <= reg_write_s;
      LoadE     <= load_s;
    end
  end

  // Saturating stall and flush event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCnt <= {CNT_W{1'b0}};
      FlushCnt <= {CNT_W{1'b0}};
    end else begin
      if (lw_stall_s && (StallCnt != CNT_MAX)) begin
        StallCnt <= StallCnt + CNT_ONE;
      end else begin
        StallCnt <= StallCnt;
      end
      if (PCSrcE && (FlushCnt != CNT_MAX)) begin
        FlushCnt <= FlushCnt + CNT_ONE;
      end else begin
        FlushCnt <= FlushCnt;
      end
    end
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_decode_hazard_ctrl
//
// Directed, self-checking bench for decode_hazard_ctrl. A second instance with
// a 4-bit counter width shares the stimulus and exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_decode_hazard_ctrl;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] LW5 = 32'h0000A283;  // lw  x5,0(x1)
  localparam logic [31:0] ADD = 32'h00128333;  // add x6,x5,x1
  localparam logic [31:0] SW5 = 32'h00512423;  // sw  x5,8(x2)
  localparam logic [31:0] LW0 = 32'h0000A003;  // lw  x0,0(x1)
  localparam logic [31:0] LUI = 32'h000010B7;  // lui x1,1
  localparam logic [31:0] JAL = 32'h0000006F;  // jal x0,0
  localparam logic [31:0] BEQ = 32'h00000063;  // beq x0,x0,0
  localparam logic [31:0] ADI = 32'h00A00093;  // addi x1,x0,10

  logic        clk;
  logic        reset;
  logic [31:0] InstrF;
  logic        PCSrcE;
  logic [31:0] ImmExtD;

  logic [31:0] InstrD, ImmExtE;
  logic [1:0]  ImmSrcD;
  logic        IllegalD, RegWriteE, LoadE, StallF, StallD, FlushD, FlushE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [15:0] StallCnt, FlushCnt;

  logic [31:0] s_InstrD, s_ImmExtE;
  logic [1:0]  s_ImmSrcD;
  logic        s_IllegalD, s_RegWriteE, s_LoadE, s_StallF, s_StallD, s_FlushD, s_FlushE;
  logic [4:0]  s_Rs1E, s_Rs2E, s_RdE;
  logic [3:0]  s_StallCnt, s_FlushCnt;

  int passed;
  int total;

  decode_hazard_ctrl dut (
    .clk(clk), .reset(reset), .InstrF(InstrF), .PCSrcE(PCSrcE), .ImmExtD(ImmExtD),
    .InstrD(InstrD), .ImmSrcD(ImmSrcD), .IllegalD(IllegalD), .ImmExtE(ImmExtE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE), .LoadE(LoadE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  decode_hazard_ctrl #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .InstrF(InstrF), .PCSrcE(PCSrcE), .ImmExtD(ImmExtD),
    .InstrD(s_InstrD), .ImmSrcD(s_ImmSrcD), .IllegalD(s_IllegalD), .ImmExtE(s_ImmExtE),
    .Rs1E(s_Rs1E), .Rs2E(s_Rs2E), .RdE(s_RdE), .RegWriteE(s_RegWriteE), .LoadE(s_LoadE),
    .StallF(s_StallF), .StallD(s_StallD), .FlushD(s_FlushD), .FlushE(s_FlushE),
    .StallCnt(s_StallCnt), .FlushCnt(s_FlushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then stable 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; PCSrcE = 1'b0; ImmExtD = 32'h0; InstrF = ADD;
    step(); step();
    total++; if (InstrD !== NOP) $display("FAIL reset_instrd got %h want %h", InstrD, NOP); else passed++;
    total++; if (RdE !== 5'd0) $display("FAIL reset_rde got %0d want 0", RdE); else passed++;
    total++; if (StallCnt !== 16'd0 || FlushCnt !== 16'd0) $display("FAIL reset_cnt got %0d/%0d want 0/0", StallCnt, FlushCnt); else passed++;
    total++; if ({ImmSrcD, IllegalD, StallF, StallD, FlushD, FlushE, RegWriteE, LoadE} !== 9'd0)
      $display("FAIL reset_ctrl got %b want 0", {ImmSrcD, IllegalD, StallF, StallD, FlushD, FlushE, RegWriteE, LoadE}); else passed++;
    reset = 1'b0;
    step();
    total++; if (InstrD !== ADD) $display("FAIL post_reset_instrd got %h want %h", InstrD, ADD); else passed++;
    total++; if (ImmSrcD !== 2'b00) $display("FAIL post_reset_immsrc got %b want 00", ImmSrcD); else passed++;
  endtask

  task automatic test_load_use();
    InstrF = LW5; step();           // D=lw, E=add
    InstrF = ADD; step();           // D=add, E=lw -> stall
    total++; if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) $display("FAIL lu_stall got %b want 1110", {StallF, StallD, FlushE, FlushD}); else passed++;
    total++; if (RdE !== 5'd5 || LoadE !== 1'b1) $display("FAIL lu_load_in_e got rd=%0d ld=%b want rd=5 ld=1", RdE, LoadE); else passed++;
    InstrF = NOP; step();           // D held, E bubble
    total++; if (InstrD !== ADD) $display("FAIL lu_hold got %h want %h", InstrD, ADD); else passed++;
    total++; if (RdE !== 5'd0 || LoadE !== 1'b0) $display("FAIL lu_bubble got rd=%0d ld=%b want 0/0", RdE, LoadE); else passed++;
    total++; if (StallF !== 1'b0 || FlushE !== 1'b0) $display("FAIL lu_one_cycle got %b%b want 00", StallF, FlushE); else passed++;
    step();                          // add reaches E
    total++; if (RdE !== 5'd6 || RegWriteE !== 1'b1) $display("FAIL lu_add_e got rd=%0d rw=%b want 6/1", RdE, RegWriteE); else passed++;
    total++; if (StallCnt !== 16'd1) $display("FAIL lu_cnt got %0d want 1", StallCnt); else passed++;
  endtask

  task automatic test_store_rs2();
    InstrF = LW5; step();
    InstrF = SW5; step();           // D=sw, E=lw
    total++; if (StallD !== 1'b1) $display("FAIL st_stall got %b want 1", StallD); else passed++;
    total++; if (ImmSrcD !== 2'b01) $display("FAIL st_immsrc got %b want 01", ImmSrcD); else passed++;
    ImmExtD = 32'h8; InstrF = NOP; step();
    total++; if (ImmExtE !== 32'h0 || StallD !== 1'b0) $display("FAIL st_bubble got imm=%h st=%b want 0/0", ImmExtE, StallD); else passed++;
    step();
    total++; if (ImmExtE !== 32'h8) $display("FAIL st_immext got %h want 00000008", ImmExtE); else passed++;
    total++; if ({Rs1E, Rs2E, RdE, RegWriteE} !== {5'd2, 5'd5, 5'd8, 1'b0})
      $display("FAIL st_fields got %0d %0d %0d %b want 2 5 8 0", Rs1E, Rs2E, RdE, RegWriteE); else passed++;
    total++; if (StallCnt !== 16'd2) $display("FAIL st_cnt got %0d want 2", StallCnt); else passed++;
    ImmExtD = 32'h0;
  endtask

  task automatic test_x0_no_stall();
    InstrF = LW0; step();
    InstrF = NOP; step();           // D=nop reads x0, E=lw x0
    total++; if (LoadE !== 1'b1 || StallF !== 1'b0) $display("FAIL x0_stall got ld=%b st=%b want 1/0", LoadE, StallF); else passed++;
    step();
    total++; if (StallCnt !== 16'd2) $display("FAIL x0_cnt got %0d want 2", StallCnt); else passed++;
  endtask

  task automatic test_flush_vs_stall();
    InstrF = LW5; step();
    InstrF = ADD; step();           // stall condition active
    PCSrcE = 1'b1; InstrF = ADI; #1;
    total++; if ({StallD, FlushD, FlushE} !== 3'b111) $display("FAIL fl_ctrl got %b want 111", {StallD, FlushD, FlushE}); else passed++;
    step();
    PCSrcE = 1'b0;
    total++; if (InstrD !== NOP) $display("FAIL fl_instrd got %h want %h", InstrD, NOP); else passed++;
    total++; if ({ImmExtE, Rs1E, Rs2E, RdE, RegWriteE, LoadE} !== 49'd0) $display("FAIL fl_e_clear got rd=%0d ld=%b rw=%b", RdE, LoadE, RegWriteE); else passed++;
    total++; if (StallCnt !== 16'd3 || FlushCnt !== 16'd1) $display("FAIL fl_cnt got %0d/%0d want 3/1", StallCnt, FlushCnt); else passed++;
  endtask

  task automatic test_decode();
    InstrF = LUI; step();
    total++; if (IllegalD !== 1'b1 || ImmSrcD !== 2'b00) $display("FAIL lui_illegal got %b/%b want 1/00", IllegalD, ImmSrcD); else passed++;
    InstrF = JAL; step();
    total++; if (RegWriteE !== 1'b0 || RdE !== 5'd1) $display("FAIL lui_e got rw=%b rd=%0d want 0/1", RegWriteE, RdE); else passed++;
    total++; if (ImmSrcD !== 2'b11 || IllegalD !== 1'b0) $display("FAIL jal_immsrc got %b/%b want 11/0", ImmSrcD, IllegalD); else passed++;
    InstrF = BEQ; step();
    total++; if (ImmSrcD !== 2'b10) $display("FAIL beq_immsrc got %b want 10", ImmSrcD); else passed++;
    InstrF = NOP; step();
  endtask

  task automatic test_reset_mid_stall();
    InstrF = LW5; step();
    InstrF = ADD; step();
    PCSrcE = 1'b1; reset = 1'b1; step();
    reset = 1'b0; PCSrcE = 1'b0;
    total++; if (InstrD !== NOP || LoadE !== 1'b0 || RdE !== 5'd0) $display("FAIL rst_mid got %h ld=%b rd=%0d", InstrD, LoadE, RdE); else passed++;
    total++; if (StallCnt !== 16'd0 || FlushCnt !== 16'd0) $display("FAIL rst_mid_cnt got %0d/%0d want 0/0", StallCnt, FlushCnt); else passed++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      InstrF = LW5; step();
      InstrF = ADD; step();
      InstrF = NOP; step();
    end
    total++; if (StallCnt !== 16'd20) $display("FAIL sat_stall_wide got %0d want 20", StallCnt); else passed++;
    total++; if (s_StallCnt !== 4'd15) $display("FAIL sat_stall got %0d want 15", s_StallCnt); else passed++;
    PCSrcE = 1'b1;
    for (int i = 0; i < 20; i++) step();
    PCSrcE = 1'b0;
    total++; if (FlushCnt !== 16'd20) $display("FAIL sat_flush_wide got %0d want 20", FlushCnt); else passed++;
    total++; if (s_FlushCnt !== 4'd15 || s_StallCnt !== 4'd15) $display("FAIL sat_flush got %0d/%0d want 15/15", s_FlushCnt, s_StallCnt); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset = 1'b1; InstrF = 32'h0; PCSrcE = 1'b0; ImmExtD = 32'h0;
    test_reset();
    test_load_use();
    test_store_rs2();
    test_x0_no_stall();
    test_flush_vs_stall();
    test_decode();
    test_reset_mid_stall();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
